// File: rtl/mem_stage_hs.sv
// mem_stage_hs: MEM pipeline stage that talks to data memory through a
// req/ack handshake, stalls the pipeline while an access is outstanding,
// lane-aligns store and load data, flags misaligned accesses and abandons
// accesses that wait too long for an acknowledge.
module mem_stage_hs #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              reg_write,
    input  logic              rd_src,
    input  logic [XLEN-1:0]   pc_to_reg,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [4:0]        rd_addr,
    input  logic [2:0]        funct3,
    output logic [XLEN-1:0]   fwd_rd_data,
    output logic              stall_o,
    output logic              wb_mem_to_reg,
    output logic              wb_reg_write,
    output logic [XLEN-1:0]   wb_rd_data,
    output logic [XLEN-1:0]   wb_ld_data,
    output logic [4:0]        wb_rd_addr,
    output logic              exc_misalign,
    output logic              exc_bus_err,
    output logic              dm_req,
    output logic [XLEN/8-1:0] dm_web,
    output logic [XLEN-1:0]   dm_addr,
    output logic [XLEN-1:0]   dm_wdata,
    input  logic [XLEN-1:0]   dm_rdata,
    input  logic              dm_ack
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    typedef enum logic [0:0] {S_IDLE, S_WAIT} state_e;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic            acc, misalign, timeout;
    logic            issue, finish, abort, pass;
    logic [OFFW-1:0] off;
    logic [NB-1:0]   laneMask, storeWeb;
    logic [XLEN-1:0] sizeBits, storeData, laneData, loadData;

    logic            dm_req_q, dm_req_d;
    logic [NB-1:0]   dm_web_q, dm_web_d;
    logic [XLEN-1:0] dm_addr_q, dm_addr_d;
    logic [XLEN-1:0] dm_wdata_q, dm_wdata_d;
    logic            wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic            wb_reg_write_q, wb_reg_write_d;
    logic [XLEN-1:0] wb_rd_data_q, wb_rd_data_d;
    logic [XLEN-1:0] wb_ld_data_q, wb_ld_data_d;
    logic [4:0]      wb_rd_addr_q, wb_rd_addr_d;

    assign acc         = mem_valid & (mem_read | mem_write);
    assign off         = alu_out[OFFW-1:0];
    assign fwd_rd_data = rd_src ? pc_to_reg : alu_out;
    assign timeout     = (state_q == S_WAIT) && !dm_ack && (cnt_q == 16'(MAX_WAIT - 1));

    // Alignment check by access size; doubleword and LWU do not exist on a 32-bit datapath
    always_comb begin
        misalign = 1'b0;
        case (funct3)
            3'b001, 3'b101: misalign = alu_out[0];
            3'b010, 3'b110: misalign = |alu_out[1:0];
            3'b011:         misalign = |alu_out[2:0];
            default:        misalign = 1'b0;
        endcase
        if (XLEN == 32 && (funct3 == 3'b011 || funct3 == 3'b110)) begin
            misalign = 1'b1;
        end
    end

    // Store formatting: pick the byte lanes covered by the access and shift rs2 into them
    always_comb begin
        laneMask = '0;
        case (funct3[1:0])
            2'b00:   laneMask = NB'(1);
            2'b01:   laneMask = NB'(3);
            2'b10:   laneMask = NB'(15);
            default: laneMask = '1;
        endcase
        for (int i = 0; i < NB; i++) begin
            sizeBits[8*i +: 8] = {8{laneMask[i]}};
        end
        storeWeb  = ~(laneMask << off);
        storeData = (rs2_data & sizeBits) << {off, 3'b000};
    end

    // Load formatting: bring the addressed lane down to bit 0 and extend it
    always_comb begin
        laneData = dm_rdata >> {off, 3'b000};
        loadData = '0;
        case (funct3)
            3'b000:  loadData = XLEN'($signed(laneData[7:0]));
            3'b001:  loadData = XLEN'($signed(laneData[15:0]));
            3'b010:  loadData = XLEN'($signed(laneData[31:0]));
            3'b011:  loadData = laneData;
            3'b100:  loadData = XLEN'(laneData[7:0]);
            3'b101:  loadData = XLEN'(laneData[15:0]);
            3'b110:  loadData = XLEN'(laneData[31:0]);
            default: loadData = '0;
        endcase
    end

    // State register and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: issue aligned accesses, leave WAIT on ack or when the wait budget runs out
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (acc && !misalign) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (dm_ack || timeout) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs per state: stall, exception pulses and the strobes steering the registers
    always_comb begin
        stall_o      = 1'b0;
        exc_misalign = 1'b0;
        exc_bus_err  = 1'b0;
        issue        = 1'b0;
        finish       = 1'b0;
        abort        = 1'b0;
        pass         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc && !misalign) begin
                    stall_o = 1'b1;
                    issue   = 1'b1;
                end else if (acc) begin
                    exc_misalign = 1'b1;
                end else begin
                    pass = 1'b1;
                end
            end
            S_WAIT: begin
                stall_o     = ~dm_ack & ~timeout;
                finish      = dm_ack;
                abort       = timeout;
                exc_bus_err = timeout;
            end
            default: ;
        endcase
    end

    // Next values of the memory interface and MEM/WB registers; anything not retiring becomes a bubble
    always_comb begin
        dm_req_d        = dm_req_q;
        dm_web_d        = dm_web_q;
        dm_addr_d       = dm_addr_q;
        dm_wdata_d      = dm_wdata_q;
        wb_mem_to_reg_d = 1'b0;
        wb_reg_write_d  = 1'b0;
        wb_rd_data_d    = wb_rd_data_q;
        wb_ld_data_d    = wb_ld_data_q;
        wb_rd_addr_d    = wb_rd_addr_q;
        if (issue) begin
            dm_req_d   = 1'b1;
            dm_addr_d  = {alu_out[XLEN-1:OFFW], {OFFW{1'b0}}};
            dm_web_d   = mem_read ? '1 : storeWeb;
            dm_wdata_d = mem_read ? '0 : storeData;
        end
        if (finish || abort) begin
            dm_req_d = 1'b0;
            dm_web_d = '1;
        end
        if (pass) begin
            wb_mem_to_reg_d = mem_to_reg;
            wb_reg_write_d  = reg_write & mem_valid;
            wb_rd_data_d    = fwd_rd_data;
            wb_rd_addr_d    = rd_addr;
        end
        if (finish) begin
            wb_mem_to_reg_d = mem_to_reg;
            wb_reg_write_d  = reg_write;
            wb_rd_data_d    = fwd_rd_data;
            wb_rd_addr_d    = rd_addr;
            wb_ld_data_d    = mem_read ? loadData : '0;
        end
    end

    // Memory interface and MEM/WB pipeline registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dm_req_q        <= 1'b0;
            dm_web_q        <= '1;
            dm_addr_q       <= '0;
            dm_wdata_q      <= '0;
            wb_mem_to_reg_q <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_rd_data_q    <= '0;
            wb_ld_data_q    <= '0;
            wb_rd_addr_q    <= '0;
        end else begin
            dm_req_q        <= dm_req_d;
            dm_web_q        <= dm_web_d;
            dm_addr_q       <= dm_addr_d;
            dm_wdata_q      <= dm_wdata_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_rd_data_q    <= wb_rd_data_d;
            wb_ld_data_q    <= wb_ld_data_d;
            wb_rd_addr_q    <= wb_rd_addr_d;
        end
    end

    assign dm_req        = dm_req_q;
    assign dm_web        = dm_web_q;
    assign dm_addr       = dm_addr_q;
    assign dm_wdata      = dm_wdata_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_rd_data    = wb_rd_data_q;
    assign wb_ld_data    = wb_ld_data_q;
    assign wb_rd_addr    = wb_rd_addr_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: drives a 32-bit (short wait budget) and a 64-bit instance
// with directed vectors, checks both against a cycle-level reference model
// every cycle and pins key results with hand-computed values.
module tb_mem_stage_hs;

    typedef struct packed {
        logic        valid, rd, wr, m2r, rw, rdSrc, ack;
        logic [63:0] pc, alu, rs2, rdata;
        logic [4:0]  rdAddr;
        logic [2:0]  f3;
    } InT;

    typedef struct packed {
        logic [63:0] fwd, wbRd, wbLd, addr, wdata;
        logic [7:0]  web;
        logic [4:0]  wbAddr;
        logic        stall, wbM2R, wbRW, mis, bus, req;
    } OutT;

    typedef struct packed {
        logic        busy;
        logic [31:0] waits;
        logic        req;
        logic [7:0]  web;
        logic [63:0] addr, wdata, wbRd, wbLd;
        logic        wbM2R, wbRW;
        logic [4:0]  wbAddr;
    } ModelT;

    logic clk = 1'b0;
    logic rst;
    InT   in32, in64;
    ModelT m32, m64;
    int   testsRun = 0;
    int   failures = 0;

    logic [31:0] fwd32, wbRd32, wbLd32, addr32, wdata32;
    logic [3:0]  web32;
    logic [4:0]  wbAddr32;
    logic        stall32, m2r32, rw32, mis32, bus32, req32;
    logic [63:0] fwd64, wbRd64, wbLd64, addr64, wdata64;
    logic [7:0]  web64;
    logic [4:0]  wbAddr64;
    logic        stall64, m2r64, rw64, mis64, bus64, req64;

    always #5 clk = ~clk;

    mem_stage_hs #(.XLEN(32), .MAX_WAIT(4)) dut32 (
        .clk(clk), .rst(rst),
        .mem_valid(in32.valid), .mem_read(in32.rd), .mem_write(in32.wr),
        .mem_to_reg(in32.m2r), .reg_write(in32.rw), .rd_src(in32.rdSrc),
        .pc_to_reg(in32.pc[31:0]), .alu_out(in32.alu[31:0]), .rs2_data(in32.rs2[31:0]),
        .rd_addr(in32.rdAddr), .funct3(in32.f3),
        .fwd_rd_data(fwd32), .stall_o(stall32),
        .wb_mem_to_reg(m2r32), .wb_reg_write(rw32),
        .wb_rd_data(wbRd32), .wb_ld_data(wbLd32), .wb_rd_addr(wbAddr32),
        .exc_misalign(mis32), .exc_bus_err(bus32),
        .dm_req(req32), .dm_web(web32), .dm_addr(addr32), .dm_wdata(wdata32),
        .dm_rdata(in32.rdata[31:0]), .dm_ack(in32.ack)
    );

    mem_stage_hs #(.XLEN(64), .MAX_WAIT(255)) dut64 (
        .clk(clk), .rst(rst),
        .mem_valid(in64.valid), .mem_read(in64.rd), .mem_write(in64.wr),
        .mem_to_reg(in64.m2r), .reg_write(in64.rw), .rd_src(in64.rdSrc),
        .pc_to_reg(in64.pc), .alu_out(in64.alu), .rs2_data(in64.rs2),
        .rd_addr(in64.rdAddr), .funct3(in64.f3),
        .fwd_rd_data(fwd64), .stall_o(stall64),
        .wb_mem_to_reg(m2r64), .wb_reg_write(rw64),
        .wb_rd_data(wbRd64), .wb_ld_data(wbLd64), .wb_rd_addr(wbAddr64),
        .exc_misalign(mis64), .exc_bus_err(bus64),
        .dm_req(req64), .dm_web(web64), .dm_addr(addr64), .dm_wdata(wdata64),
        .dm_rdata(in64.rdata), .dm_ack(in64.ack)
    );

    // ---------------- reference model ----------------

    function automatic int accSize(input logic [2:0] f3);
        case (f3)
            3'b001, 3'b101: return 2;
            3'b010, 3'b110: return 4;
            3'b011:         return 8;
            default:        return 1;
        endcase
    endfunction

    function automatic logic [63:0] xmask(input int xlen);
        return (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic logic [7:0] idleWeb(input int xlen);
        return (xlen == 64) ? 8'hFF : 8'h0F;
    endfunction

    function automatic bit isMisaligned(input int xlen, input logic [2:0] f3, input logic [63:0] a);
        if (xlen == 32 && (f3 == 3'b011 || f3 == 3'b110)) return 1'b1;
        return (int'(a[7:0]) % accSize(f3)) != 0;
    endfunction

    function automatic int laneOff(input int xlen, input logic [63:0] a);
        return int'(a[2:0]) % (xlen / 8);
    endfunction

    function automatic logic [63:0] loadValue(input int xlen, input logic [2:0] f3,
                                              input logic [63:0] a, input logic [63:0] rdata);
        logic [63:0] v;
        int n, off;
        if (f3 == 3'b111) return 64'd0;
        n   = accSize(f3);
        off = laneOff(xlen, a);
        v   = 64'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
        if (!f3[2] && n < 8 && v[8*n-1]) begin
            for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
        end
        return v & xmask(xlen);
    endfunction

    function automatic logic [7:0] storeWeb(input int xlen, input logic [2:0] f3, input logic [63:0] a);
        logic [7:0] w;
        int off;
        w   = idleWeb(xlen);
        off = laneOff(xlen, a);
        for (int i = 0; i < accSize(f3); i++) w[off+i] = 1'b0;
        return w;
    endfunction

    function automatic logic [63:0] storeData(input int xlen, input logic [2:0] f3,
                                              input logic [63:0] a, input logic [63:0] rs2);
        logic [63:0] v;
        int off;
        v   = 64'd0;
        off = laneOff(xlen, a);
        for (int i = 0; i < accSize(f3); i++) v[8*(off+i) +: 8] = rs2[8*i +: 8];
        return v;
    endfunction

    function automatic ModelT resetModel(input int xlen);
        ModelT m;
        m     = '0;
        m.web = idleWeb(xlen);
        return m;
    endfunction

    // One MEM cycle: produces this cycle's combinational outputs and the register values after the edge
    task automatic modelStep(input int xlen, input int maxWait, input InT in, inout ModelT m,
                             output logic st, output logic mi, output logic bu);
        logic acc;
        logic [63:0] fwd;
        acc = in.valid && (in.rd || in.wr);
        fwd = (in.rdSrc ? in.pc : in.alu) & xmask(xlen);
        st = 1'b0; mi = 1'b0; bu = 1'b0;
        if (!m.busy && !acc) begin
            m.wbM2R  = in.m2r;
            m.wbRW   = in.rw && in.valid;
            m.wbRd   = fwd;
            m.wbAddr = in.rdAddr;
        end else if (!m.busy && isMisaligned(xlen, in.f3, in.alu)) begin
            mi = 1'b1;
            m.wbM2R = 1'b0; m.wbRW = 1'b0;
        end else if (!m.busy) begin
            st = 1'b1;
            m.busy  = 1'b1;
            m.waits = 0;
            m.req   = 1'b1;
            m.addr  = (in.alu & xmask(xlen)) & ~64'(xlen/8 - 1);
            m.web   = in.rd ? idleWeb(xlen) : storeWeb(xlen, in.f3, in.alu);
            m.wdata = in.rd ? 64'd0 : storeData(xlen, in.f3, in.alu, in.rs2);
            m.wbM2R = 1'b0; m.wbRW = 1'b0;
        end else if (in.ack) begin
            m.busy   = 1'b0;
            m.req    = 1'b0;
            m.web    = idleWeb(xlen);
            m.wbM2R  = in.m2r;
            m.wbRW   = in.rw;
            m.wbRd   = fwd;
            m.wbAddr = in.rdAddr;
            m.wbLd   = in.rd ? loadValue(xlen, in.f3, in.alu, in.rdata) : 64'd0;
        end else if (m.waits == 32'(maxWait - 1)) begin
            bu = 1'b1;
            m.busy = 1'b0;
            m.req  = 1'b0;
            m.web  = idleWeb(xlen);
            m.wbM2R = 1'b0; m.wbRW = 1'b0;
        end else begin
            st = 1'b1;
            m.waits = m.waits + 1;
            m.wbM2R = 1'b0; m.wbRW = 1'b0;
        end
    endtask

    // ---------------- checking ----------------

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic OutT getOut(input bit is64);
        OutT o;
        if (is64) o = '{fwd64, wbRd64, wbLd64, addr64, wdata64, web64, wbAddr64,
                        stall64, m2r64, rw64, mis64, bus64, req64};
        else      o = '{64'(fwd32), 64'(wbRd32), 64'(wbLd32), 64'(addr32), 64'(wdata32),
                        8'(web32), wbAddr32, stall32, m2r32, rw32, mis32, bus32, req32};
        return o;
    endfunction

    task automatic compareRegs(input string tag, input OutT o, input ModelT m);
        checkOutput({tag, ".dm_req"},        64'(o.req),    64'(m.req));
        checkOutput({tag, ".dm_web"},        64'(o.web),    64'(m.web));
        checkOutput({tag, ".dm_addr"},       o.addr,        m.addr);
        checkOutput({tag, ".dm_wdata"},      o.wdata,       m.wdata);
        checkOutput({tag, ".wb_mem_to_reg"}, 64'(o.wbM2R),  64'(m.wbM2R));
        checkOutput({tag, ".wb_reg_write"},  64'(o.wbRW),   64'(m.wbRW));
        checkOutput({tag, ".wb_rd_data"},    o.wbRd,        m.wbRd);
        checkOutput({tag, ".wb_ld_data"},    o.wbLd,        m.wbLd);
        checkOutput({tag, ".wb_rd_addr"},    64'(o.wbAddr), 64'(m.wbAddr));
    endtask

    task automatic compareComb(input string tag, input int xlen, input OutT o, input InT in,
                               input logic st, input logic mi, input logic bu);
        checkOutput({tag, ".stall_o"},      64'(o.stall), 64'(st));
        checkOutput({tag, ".exc_misalign"}, 64'(o.mis),   64'(mi));
        checkOutput({tag, ".exc_bus_err"},  64'(o.bus),   64'(bu));
        checkOutput({tag, ".fwd_rd_data"},  o.fwd, (in.rdSrc ? in.pc : in.alu) & xmask(xlen));
    endtask

    // Compare both instances against the model in the middle of every cycle
    always @(negedge clk) begin
        logic st, mi, bu;
        if (rst) begin
            m32 = resetModel(32);
            m64 = resetModel(64);
            compareRegs("d32", getOut(1'b0), m32);
            compareRegs("d64", getOut(1'b1), m64);
        end else begin
            compareRegs("d32", getOut(1'b0), m32);
            modelStep(32, 4, in32, m32, st, mi, bu);
            compareComb("d32", 32, getOut(1'b0), in32, st, mi, bu);
            compareRegs("d64", getOut(1'b1), m64);
            modelStep(64, 255, in64, m64, st, mi, bu);
            compareComb("d64", 64, getOut(1'b1), in64, st, mi, bu);
        end
    end

    // ---------------- stimulus ----------------

    function automatic InT idleV();
        return '0;
    endfunction

    function automatic InT mk(input logic rd, input logic wr, input logic rw, input logic m2r,
                              input logic [63:0] alu, input logic [63:0] rs2,
                              input logic [4:0] rdAddr, input logic [2:0] f3);
        InT v;
        v        = '0;
        v.valid  = 1'b1;
        v.rd     = rd;
        v.wr     = wr;
        v.rw     = rw;
        v.m2r    = m2r;
        v.alu    = alu;
        v.rs2    = rs2;
        v.rdAddr = rdAddr;
        v.f3     = f3;
        return v;
    endfunction

    task automatic applyStimulus(input bit is64, input InT v);
        @(posedge clk);
        #1;
        if (is64) in64 = v;
        else      in32 = v;
    endtask

    initial begin
        InT v;
        rst  = 1'b1;
        in32 = idleV();
        in64 = idleV();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.dm_web32", 64'(web32), 64'hF);
        checkOutput("reset.dm_web64", 64'(web64), 64'hFF);
        checkOutput("reset.dm_req32", 64'(req32), 64'h0);
        rst = 1'b0;

        // plain ALU result, then a link value forwarded from pc_to_reg
        applyStimulus(1'b0, mk(0, 0, 1, 0, 64'h55, 64'h0, 5'd3, 3'b000));
        v       = mk(0, 0, 1, 0, 64'h55, 64'h0, 5'd4, 3'b000);
        v.rdSrc = 1'b1;
        v.pc    = 64'h100;
        applyStimulus(1'b0, v);
        #1;
        checkOutput("alu.fwd_pc", 64'(fwd32), 64'h100);
        checkOutput("alu.wb_rd_data", 64'(wbRd32), 64'h55);
        checkOutput("alu.wb_rd_addr", 64'(wbAddr32), 64'd3);

        // LB at offset 3, ack in the first WAIT cycle
        v = mk(1, 0, 1, 1, 64'h1003, 64'h0, 5'd5, 3'b000);
        applyStimulus(1'b0, v);
        #1;
        checkOutput("lb.issue_stall", 64'(stall32), 64'h1);
        v.ack   = 1'b1;
        v.rdata = 64'h80FF_1234;
        applyStimulus(1'b0, v);
        #1;
        checkOutput("lb.dm_addr", 64'(addr32), 64'h1000);
        checkOutput("lb.dm_req", 64'(req32), 64'h1);
        applyStimulus(1'b0, idleV());
        #1;
        checkOutput("lb.wb_ld_data", 64'(wbLd32), 64'hFFFF_FF80);
        checkOutput("lb.dm_req_drop", 64'(req32), 64'h0);

        // SH at offset 2, three wait cycles, ack lands on the last allowed WAIT cycle
        v = mk(0, 1, 0, 0, 64'h2002, 64'hABCD_5678, 5'd0, 3'b001);
        applyStimulus(1'b0, v);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, v);
            #1;
            checkOutput("sh.dm_req_held", 64'(req32), 64'h1);
            checkOutput("sh.dm_web", 64'(web32), 64'h3);
            checkOutput("sh.dm_wdata", 64'(wdata32), 64'h5678_0000);
        end
        v.ack = 1'b1;
        applyStimulus(1'b0, v);
        #1;
        checkOutput("sh.ack_beats_timeout", 64'(bus32), 64'h0);
        applyStimulus(1'b0, idleV());
        #1;
        checkOutput("sh.wb_ld_data", 64'(wbLd32), 64'h0);
        checkOutput("sh.dm_web_idle", 64'(web32), 64'hF);

        // misaligned LW after a writing ALU op
        applyStimulus(1'b0, mk(0, 0, 1, 0, 64'h11, 64'h0, 5'd2, 3'b000));
        applyStimulus(1'b0, mk(1, 0, 1, 1, 64'h3001, 64'h0, 5'd7, 3'b010));
        #1;
        checkOutput("lw_mis.exc_misalign", 64'(mis32), 64'h1);
        checkOutput("lw_mis.stall", 64'(stall32), 64'h0);
        applyStimulus(1'b0, idleV());
        #1;
        checkOutput("lw_mis.wb_reg_write", 64'(rw32), 64'h0);
        checkOutput("lw_mis.dm_req", 64'(req32), 64'h0);

        // timeout with a budget of 4 WAIT cycles, then a late ack in IDLE
        v = mk(1, 0, 1, 1, 64'h4000, 64'h0, 5'd8, 3'b010);
        applyStimulus(1'b0, v);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, v);
            #1;
            checkOutput("to.no_err_yet", 64'(bus32), 64'h0);
        end
        applyStimulus(1'b0, v);
        #1;
        checkOutput("to.exc_bus_err", 64'(bus32), 64'h1);
        checkOutput("to.stall", 64'(stall32), 64'h0);
        v     = idleV();
        v.ack = 1'b1;
        applyStimulus(1'b0, v);
        #1;
        checkOutput("to.dm_req_drop", 64'(req32), 64'h0);
        checkOutput("to.late_ack_stall", 64'(stall32), 64'h0);
        applyStimulus(1'b0, idleV());
        #1;
        checkOutput("to.late_ack_ignored", 64'(req32), 64'h0);

        // reset in the middle of a WAIT
        applyStimulus(1'b0, mk(0, 0, 1, 0, 64'h77, 64'h0, 5'd9, 3'b000));
        v = mk(1, 0, 1, 1, 64'h1001, 64'h0, 5'd10, 3'b000);
        applyStimulus(1'b0, v);
        applyStimulus(1'b0, v);
        #1;
        checkOutput("rstmid.dm_req_before", 64'(req32), 64'h1);
        checkOutput("rstmid.wb_rd_before", 64'(wbRd32), 64'h77);
        #1;
        rst  = 1'b1;
        in32 = idleV();
        #1;
        checkOutput("rstmid.dm_req", 64'(req32), 64'h0);
        checkOutput("rstmid.dm_web", 64'(web32), 64'hF);
        checkOutput("rstmid.wb_rd_data", 64'(wbRd32), 64'h0);
        checkOutput("rstmid.wb_rd_addr", 64'(wbAddr32), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        v = mk(1, 0, 1, 1, 64'h1002, 64'h0, 5'd11, 3'b000);
        applyStimulus(1'b0, v);
        #1;
        checkOutput("postrst.stall", 64'(stall32), 64'h1);
        v.ack   = 1'b1;
        v.rdata = 64'h80FF_1234;
        applyStimulus(1'b0, v);
        #1;
        checkOutput("postrst.dm_addr", 64'(addr32), 64'h1000);
        applyStimulus(1'b0, idleV());
        #1;
        checkOutput("postrst.wb_ld_data", 64'(wbLd32), 64'hFFFF_FFFF);
        checkOutput("postrst.wb_rd_addr", 64'(wbAddr32), 64'd11);

        // 64-bit: LWU at offset 4
        v = mk(1, 0, 1, 1, 64'h5004, 64'h0, 5'd12, 3'b110);
        applyStimulus(1'b1, v);
        v.ack   = 1'b1;
        v.rdata = 64'hDEAD_BEEF_0000_0001;
        applyStimulus(1'b1, v);
        #1;
        checkOutput("lwu.dm_addr", addr64, 64'h5000);
        applyStimulus(1'b1, idleV());
        #1;
        checkOutput("lwu.wb_ld_data", wbLd64, 64'h0000_0000_DEAD_BEEF);

        // 64-bit: LW sign extension, one wait cycle before ack
        v = mk(1, 0, 1, 1, 64'h6004, 64'h0, 5'd13, 3'b010);
        v.rdata = 64'h8000_0000_0000_0000;
        applyStimulus(1'b1, v);
        applyStimulus(1'b1, v);
        v.ack = 1'b1;
        applyStimulus(1'b1, v);
        applyStimulus(1'b1, idleV());
        #1;
        checkOutput("lw64.wb_ld_data", wbLd64, 64'hFFFF_FFFF_8000_0000);

        // 64-bit: SB into lane 5
        v = mk(0, 1, 0, 0, 64'h7005, 64'h1234_56AB, 5'd0, 3'b000);
        applyStimulus(1'b1, v);
        v.ack = 1'b1;
        applyStimulus(1'b1, v);
        #1;
        checkOutput("sb64.dm_web", 64'(web64), 64'hDF);
        checkOutput("sb64.dm_wdata", wdata64, 64'h0000_AB00_0000_0000);
        applyStimulus(1'b1, idleV());

        // 64-bit: LD passes the whole word through
        v = mk(1, 0, 1, 1, 64'h8000, 64'h0, 5'd14, 3'b011);
        applyStimulus(1'b1, v);
        v.ack   = 1'b1;
        v.rdata = 64'h0123_4567_89AB_CDEF;
        applyStimulus(1'b1, v);
        applyStimulus(1'b1, idleV());
        #1;
        checkOutput("ld64.wb_ld_data", wbLd64, 64'h0123_4567_89AB_CDEF);

        // 64-bit: SD at a word (not doubleword) boundary is misaligned
        applyStimulus(1'b1, mk(0, 1, 0, 0, 64'h9004, 64'h1, 5'd0, 3'b011));
        #1;
        checkOutput("sd64.exc_misalign", 64'(mis64), 64'h1);
        applyStimulus(1'b1, idleV());
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

    // Guard against a run that never reaches the summary
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
